// File: rtl/reduction_term_accumulator.sv
// Accumulates NUM_BEATS beats of NUM_TERMS reduced ROM terms onto the low product half.
// The result is an unreduced sum with guard bits, handed to the final-reduction stage.
//
// state | meaning
// IDLE  | waiting for start; term_valid ignored
// ACCUM | adding one beat of terms per accepted term_valid
// DONE  | one-cycle completion; start here chains the next reduction
module reduction_term_accumulator #(
  parameter int MODULUS_WIDTH = 1024,
  parameter int NUM_TERMS     = 4,
  parameter int NUM_BEATS     = 8,
  localparam int GUARD        = $clog2(NUM_TERMS * NUM_BEATS + 1),
  localparam int SUM_W        = MODULUS_WIDTH + GUARD
) (
  input  logic                           clk_phase,
  input  logic                           reset,
  input  logic                           ce,
  input  logic                           start,
  input  logic [MODULUS_WIDTH-1:0]       base_in,
  input  logic                           term_valid,
  input  logic [NUM_TERMS*MODULUS_WIDTH-1:0] term_in,
  output logic                           busy,
  output logic                           done,
  output logic [SUM_W-1:0]               sum_out
);

  localparam int CNT_W = $clog2(NUM_BEATS + 1);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(NUM_BEATS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [SUM_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
  logic [SUM_W-1:0] beat_sum;

  // Terms are zero-extended before adding so no modular wrap can occur.
  always_comb begin
    beat_sum = '0;
    for (int t = 0; t < NUM_TERMS; t++) begin
      beat_sum = beat_sum + SUM_W'(term_in[t*MODULUS_WIDTH +: MODULUS_WIDTH]);
    end
  end

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    beat_cnt_d = beat_cnt_q;
    if (ce) begin
      case (state_q)
        IDLE: begin
          if (start) begin
            acc_d      = SUM_W'(base_in);
            beat_cnt_d = '0;
            state_d    = ACCUM;
          end
        end
        ACCUM: begin
          if (term_valid) begin
            acc_d      = acc_q + beat_sum;
            beat_cnt_d = beat_cnt_q + CNT_W'(1);
            if (beat_cnt_q == LAST_BEAT) begin
              state_d = DONE;
            end
          end
        end
        DONE: begin
          // A start here skips IDLE so reductions can run back to back.
          if (start) begin
            acc_d      = SUM_W'(base_in);
            beat_cnt_d = '0;
            state_d    = ACCUM;
          end else begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_phase or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      acc_q      <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  assign busy    = (state_q == ACCUM);
  assign done    = (state_q == DONE);
  assign sum_out = acc_q;

endmodule

// File: tb/tb_reduction_term_accumulator.sv
// Directed bench for reduction_term_accumulator with W=16, two terms, three beats.
module tb_reduction_term_accumulator;

  localparam int W   = 16;
  localparam int NT  = 2;
  localparam int NB  = 3;
  localparam int SW  = W + $clog2(NT * NB + 1);

  logic              clk_phase = 1'b0;
  logic              reset;
  logic              ce;
  logic              start;
  logic [W-1:0]      base_in;
  logic              term_valid;
  logic [NT*W-1:0]   term_in;
  logic              busy;
  logic              done;
  logic [SW-1:0]     sum_out;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc_n    = 0;
  int t_start;
  int t_done;
  int busy_cnt;

  reduction_term_accumulator #(
    .MODULUS_WIDTH(W),
    .NUM_TERMS    (NT),
    .NUM_BEATS    (NB)
  ) dut (
    .clk_phase (clk_phase),
    .reset     (reset),
    .ce        (ce),
    .start     (start),
    .base_in   (base_in),
    .term_valid(term_valid),
    .term_in   (term_in),
    .busy      (busy),
    .done      (done),
    .sum_out   (sum_out)
  );

  always #5 clk_phase = ~clk_phase;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Apply one cycle of inputs, then sample 1 time unit after the rising edge.
  task automatic cyc_in(input logic c, input logic s, input logic [W-1:0] b,
                        input logic tv, input logic [W-1:0] a0, input logic [W-1:0] a1);
    ce         = c;
    start      = s;
    base_in    = b;
    term_valid = tv;
    term_in    = {a1, a0};
    @(posedge clk_phase);
    #1;
    cyc_n++;
    if (busy) busy_cnt++;
    if (done && t_done < 0) t_done = cyc_n;
  endtask

  task automatic idle_cyc();
    cyc_in(1'b1, 1'b0, '0, 1'b0, '0, '0);
  endtask

  task automatic mark_start(input logic [W-1:0] b);
    t_done   = -1;
    busy_cnt = 0;
    cyc_in(1'b1, 1'b1, b, 1'b0, '0, '0);
    t_start = cyc_n;
  endtask

  initial begin
    reset = 1'b1; ce = 1'b0; start = 1'b0; base_in = '0;
    term_valid = 1'b0; term_in = '0;
    t_done = -1; t_start = 0; busy_cnt = 0;
    #3;
    check_eq("reset_busy", busy, 0);
    check_eq("reset_done", done, 0);
    check_eq("reset_sum", sum_out, 0);
    @(posedge clk_phase); #2;
    reset = 1'b0;
    idle_cyc();

    // Basic sum: 0x10 + 1+2+3+4+5+6 = 0x25
    mark_start(16'h0010);
    check_eq("basic_load", sum_out, 32'h10);
    check_eq("basic_busy0", busy, 1);
    cyc_in(1, 0, '0, 1, 16'd1, 16'd2);
    check_eq("basic_beat1", sum_out, 32'h13);
    cyc_in(1, 0, '0, 1, 16'd3, 16'd4);
    check_eq("basic_beat2", sum_out, 32'h1A);
    check_eq("basic_done_early", done, 0);
    cyc_in(1, 0, '0, 1, 16'd5, 16'd6);
    check_eq("basic_done", done, 1);
    check_eq("basic_busy_end", busy, 0);
    check_eq("basic_sum", sum_out, 32'h25);
    check_eq("basic_latency", t_done - t_start + 1, 4);
    idle_cyc();
    check_eq("basic_done_pulse", done, 0);
    check_eq("basic_busy_cycles", busy_cnt, 3);
    check_eq("basic_sum_hold", sum_out, 32'h25);

    // Max operands: 7 * 0xFFFF with no truncation
    mark_start(16'hFFFF);
    for (int i = 0; i < NB; i++) cyc_in(1, 0, '0, 1, 16'hFFFF, 16'hFFFF);
    check_eq("max_done", done, 1);
    check_eq("max_sum", sum_out, 32'h6FFF9);
    check_eq("max_fits", (sum_out < (1 << SW)) ? 1 : 0, 1);
    idle_cyc();

    // Bubbles (2) and ce low (3) add exactly 5 cycles
    mark_start(16'h0010);
    cyc_in(1, 0, '0, 1, 16'd1, 16'd2);
    cyc_in(1, 0, '0, 0, 16'd9, 16'd9);
    cyc_in(1, 0, '0, 0, 16'd9, 16'd9);
    check_eq("bubble_hold", sum_out, 32'h13);
    cyc_in(1, 0, '0, 1, 16'd3, 16'd4);
    for (int i = 0; i < 3; i++) begin
      cyc_in(0, 0, '0, 1, 16'd5, 16'd6);
      check_eq("ce_freeze_sum", sum_out, 32'h1A);
      check_eq("ce_freeze_busy", busy, 1);
    end
    cyc_in(1, 0, '0, 1, 16'd5, 16'd6);
    check_eq("bubble_sum", sum_out, 32'h25);
    check_eq("bubble_latency", t_done - t_start + 1, 9);
    cyc_in(0, 0, '0, 0, '0, '0);
    cyc_in(0, 0, '0, 0, '0, '0);
    check_eq("ce_done_held", done, 1);
    idle_cyc();
    check_eq("ce_done_release", done, 0);

    // Ignored inputs: terms in IDLE, start during ACCUM
    cyc_in(1, 0, '0, 1, 16'd7, 16'd7);
    check_eq("idle_tv_busy", busy, 0);
    check_eq("idle_tv_sum", sum_out, 32'h25);
    mark_start(16'h0010);
    cyc_in(1, 0, '0, 1, 16'd1, 16'd2);
    cyc_in(1, 1, 16'h1111, 0, '0, '0);
    check_eq("accum_start_sum", sum_out, 32'h13);
    check_eq("accum_start_busy", busy, 1);
    cyc_in(1, 0, '0, 1, 16'd3, 16'd4);
    cyc_in(1, 0, '0, 1, 16'd5, 16'd6);
    check_eq("ignored_sum", sum_out, 32'h25);
    check_eq("ignored_done", done, 1);

    // Back-to-back: start during DONE, no IDLE in between
    cyc_in(1, 1, 16'h0001, 0, '0, '0);
    check_eq("b2b_busy", busy, 1);
    check_eq("b2b_done_off", done, 0);
    check_eq("b2b_load", sum_out, 32'h1);
    t_done = -1;
    for (int i = 0; i < NB; i++) cyc_in(1, 0, '0, 1, 16'd0, 16'd0);
    check_eq("b2b_done", done, 1);
    check_eq("b2b_sum", sum_out, 32'h1);
    idle_cyc();

    // Reset mid-operation clears asynchronously
    mark_start(16'h0010);
    cyc_in(1, 0, '0, 1, 16'd1, 16'd2);
    cyc_in(1, 0, '0, 1, 16'd3, 16'd4);
    #2 reset = 1'b1;
    #1;
    check_eq("rst_async_busy", busy, 0);
    check_eq("rst_async_done", done, 0);
    check_eq("rst_async_sum", sum_out, 0);
    #1 reset = 1'b0;
    cyc_in(1, 0, '0, 1, 16'd5, 16'd6);
    cyc_in(1, 0, '0, 1, 16'd5, 16'd6);
    check_eq("rst_after_busy", busy, 0);
    check_eq("rst_after_done", done, 0);
    check_eq("rst_after_sum", sum_out, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "bench timeout");
  end

endmodule

// File: doc/reduction_term_accumulator.md
# reduction_term_accumulator

Sequential accumulator directly downstream of the nonuple modulus lookup ROMs in the modular-squaring reduction path. Each beat it receives NUM_TERMS reduced partial terms, which are the ROM outputs for one group of 9-bit upper-product chunks. It adds them, together with the low half of the product, into a single unreduced sum carrying guard bits. It then signals completion to the final-reduction stage.

## Interface
- MODULUS_WIDTH, 1024, width of each term and of the base operand
- NUM_TERMS, 4, ROM outputs summed per beat
- NUM_BEATS, 8, beats per reduction (≥1)
- GUARD (localparam), $clog2(NUM_TERMS*NUM_BEATS+1), extra sum bits
- clk_phase  input  1  clock; all state updates on rising edge
- reset  input  1  asynchronous, active-high; clears all state
- ce  input  1  clock enable; when low, all state holds
- start  input  1  begin a reduction; loads base_in
- base_in  input  MODULUS_WIDTH  low half of product (< 2^MODULUS_WIDTH)
- term_valid  input  1  term_in holds one beat of ROM outputs
- term_in  input  NUM_TERMS*MODULUS_WIDTH  term t at bits [t*W +: W]
- busy  output  1  accumulation in progress
- done  output  1  one-cycle completion pulse
- sum_out  output  MODULUS_WIDTH+GUARD  accumulated sum, zero-extended

## Operation
- States: IDLE, ACCUM, DONE. Reset: state=IDLE, acc=0, beat_cnt=0, busy=0, done=0, sum_out=0.
- IDLE or DONE, ce & start:
  - acc ← zero-extended base_in, beat_cnt ← 0, state ← ACCUM.
  - start in DONE gives back-to-back operation; it overrides the DONE→IDLE return.
- IDLE, no start: hold. term_valid is ignored.
- ACCUM, ce & term_valid:
  - acc ← acc + Σ term_in[t], summed full width, no modular wrap.
  - beat_cnt increments.
  - If beat_cnt was NUM_BEATS-1, state ← DONE.
- ACCUM, start: ignored. No restart, no reload.
- ACCUM, term_valid low: hold with no penalty. Bubbles are allowed.
- DONE, ce & no start: state ← IDLE.
- Outputs:
  - busy = (state==ACCUM). done = (state==DONE). sum_out = acc.
  - sum_out holds its value until the next accepted start.
- Width rule:
  - The maximum value is (NUM_TERMS*NUM_BEATS+1)*(2^W−1), which fits W+GUARD bits.
  - Overflow is impossible. Overflow checking is not required in RTL; the bench asserts it.
- Terms are never reduced here. Final reduction of sum_out is the downstream block's job.
- ce low in any state freezes state, acc, beat_cnt and outputs. A held done stays high until a ce-enabled edge.
- reset asserted mid-ACCUM:
  - Immediately returns to the reset values. The partial sum is discarded.
  - After release, a new start is required.

## Timing
- start accepted at edge k: busy=1 from edge k, acc=base_in.
- Beat accepted at edge j adds its terms. The result is visible on sum_out after edge j.
- Final (NUM_BEATS-th) beat accepted at edge f: busy=0 and done=1 after edge f, with the final sum_out. done=0 after edge f+1 if ce=1.
- Minimum latency from start to done is NUM_BEATS+1 edges (start edge plus one edge per beat).
- Alignment with the ROM stage:
  - The ROM stage registers its index and has a one-cycle lookup latency.
  - Upstream asserts term_valid in the cycle mod_out is valid. This block adds no alignment delay.
- Adder path is combinational across NUM_TERMS+1 operands into acc. The implementation may use a carry-save tree internally but must keep the single-cycle-per-beat contract.

## Test plan
Bench parameters: W=16, NUM_TERMS=2, NUM_BEATS=3, giving GUARD=3 and a 19-bit sum.
- Basic sum: start with base_in=0x0010, then beats (1,2),(3,4),(5,6) on consecutive cycles. Required: done pulses once, 4 edges after start; sum_out=0x00025; busy high for exactly 3 cycles.
- Max/overflow: base_in=0xFFFF and all terms 0xFFFF. Required: sum_out=0x6FFF9, no truncation.
- Bubbles and ce: same stimulus as the basic sum with term_valid low for 2 cycles between beats, and ce low for 3 cycles mid-ACCUM. Required: sum_out=0x00025; done is delayed by exactly 5 cycles; outputs frozen while ce=0.
- Ignored inputs:
  - term_valid=1 with terms (7,7) while IDLE.
  - start with base_in=0x1111 during ACCUM.
  - Required: no effect; basic-sum result is still 0x00025.
- Back-to-back: start asserted in the DONE cycle with base_in=0x0001, then 3 beats of (0,0). Required: first done with 0x00025, then a second done with sum_out=0x00001; no intermediate IDLE cycle.
- Reset mid-op: assert reset after 2 beats. Required: busy, done and sum_out go to 0 asynchronously, and later beats without a new start are ignored.
